// File: rtl/bpsk_pkg.sv
// Shared constants, state type and quarter-wave table generator for the BPSK modulator.
package bpsk_pkg;

    localparam int ACC_W_DEF = 32;
    localparam int IDX_W_DEF = 10;
    localparam int DAC_W_DEF = 10;
    localparam int SYM_W_DEF = 16;

    localparam int DAC_MID = 512;
    localparam int AMP     = 511;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // round(amp * sin(i * pi / (2 * qn))) in Q30 fixed point, Taylor series to x^13.
    function automatic int quarter_sine(input int i, input int qn, input int amp);
        longint x;
        longint x2;
        longint term;
        longint s;
        x    = (longint'(i) * 64'sd3373259426) / longint'(2 * qn);
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int k = 1; k <= 6; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return int'((s * longint'(amp) + 64'sd536870912) >>> 30);
    endfunction

endpackage

// File: rtl/bpsk_sine_lut.sv
// Quarter-wave sine ROM with quadrant folding; registered signed output (pipeline stage 1).
module bpsk_sine_lut
    import bpsk_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int DAC_W = DAC_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [IDX_W-1:0]        idx_i,
    output logic signed [DAC_W-1:0] sample_o
);

    localparam int QN = 2 ** (IDX_W - 2);

    logic [DAC_W-2:0] rom [QN];

    for (genvar g = 0; g < QN; g++) begin : g_rom
        localparam int V = quarter_sine(g, QN, AMP);
        assign rom[g] = (DAC_W-1)'(V);
    end

    logic [1:0]              quad;
    logic [IDX_W-3:0]        addr;
    logic [IDX_W-3:0]        addr_m;
    logic [DAC_W-2:0]        mag;
    logic signed [DAC_W-1:0] mag_s;
    logic signed [DAC_W-1:0] sample_d;
    logic signed [DAC_W-1:0] sample_q;

    // Odd quadrants read the table mirrored; their first point is the peak, which the table lacks.
    always_comb begin
        quad   = idx_i[IDX_W-1 -: 2];
        addr   = idx_i[IDX_W-3:0];
        addr_m = quad[0] ? ('0 - addr) : addr;
        mag    = rom[addr_m];
        if (quad[0] && (addr == '0)) begin
            mag = (DAC_W-1)'(AMP);
        end
        mag_s    = signed'({1'b0, mag});
        sample_d = quad[1] ? -mag_s : mag_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q <= '0;
        end else if (en) begin
            sample_q <= sample_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/bpsk_mod.sv
// BPSK modulator: serial bits over valid/ready, phase-continuous DDS carrier, offset-binary DAC code.
// Optional differential encoding with in_last frame marker: define BPSK_MOD_DIFF_ENC_EN.
module bpsk_mod
    import bpsk_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int IDX_W = IDX_W_DEF,
    parameter int DAC_W = DAC_W_DEF,
    parameter int SYM_W = SYM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [ACC_W-1:0] fcw,
    input  logic [SYM_W-1:0] sym_len,
    input  logic             bit_valid,
    input  logic             bit_data,
`ifdef BPSK_MOD_DIFF_ENC_EN
    input  logic             in_last,
`endif
    output logic             bit_ready,
    output logic [DAC_W-1:0] dac_data,
    output logic             sym_strobe,
    output logic             busy,
    output logic             underflow
);

    // Handshake: a bit transfers on a rising clk where bit_valid and bit_ready are both high;
    // bit_ready only rises in IDLE or on the last cycle of a symbol, and never while en is low.

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [SYM_W-1:0] cnt_q, cnt_d;
    logic [SYM_W-1:0] len_q, len_d;
    logic             flip_q, flip_d;
    logic             uf_q, uf_d;
    logic             first_q, first_d;
    logic             ready_c;
    logic             load;
    logic             frame_start;
    logic             flip_new;
`ifdef BPSK_MOD_DIFF_ENC_EN
    logic             d_q, d_d;
    logic             last_q, last_d;
`endif

    logic                    gate1_q;
    logic                    strobe1_q;
    logic [DAC_W-1:0]        dac_q;
    logic                    strobe2_q;
    logic [IDX_W-1:0]        idx;
    logic signed [DAC_W-1:0] sample;

    always_comb begin
        acc_d       = acc_q + fcw;
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        flip_d      = flip_q;
        uf_d        = uf_q;
        first_d     = 1'b0;
        ready_c     = 1'b0;
        load        = 1'b0;
        frame_start = 1'b0;
`ifdef BPSK_MOD_DIFF_ENC_EN
        d_d         = d_q;
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
                ready_c = en & rst_n;
                if (bit_valid && ready_c) begin
                    load        = 1'b1;
                    frame_start = 1'b1;
                    state_d     = RUN;
                    len_d       = (sym_len < SYM_W'(2)) ? SYM_W'(2) : sym_len;
                end
            end
            RUN: begin
                cnt_d = cnt_q + SYM_W'(1);
                if (cnt_q == len_q - SYM_W'(1)) begin
                    ready_c = en & rst_n;
                    if (bit_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
`ifdef BPSK_MOD_DIFF_ENC_EN
                        if (!last_q) begin
                            uf_d = 1'b1;
                        end
`else
                        uf_d = 1'b1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef BPSK_MOD_DIFF_ENC_EN
        flip_new = (frame_start ? 1'b0 : d_q) ^ bit_data;
`else
        flip_new = bit_data;
`endif
        if (load) begin
            cnt_d   = '0;
            first_d = 1'b1;
            flip_d  = flip_new;
`ifdef BPSK_MOD_DIFF_ENC_EN
            d_d     = flip_new;
            last_d  = in_last;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            flip_q  <= 1'b0;
            uf_q    <= 1'b0;
            first_q <= 1'b0;
`ifdef BPSK_MOD_DIFF_ENC_EN
            d_q     <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else if (en) begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            flip_q  <= flip_d;
            uf_q    <= uf_d;
            first_q <= first_d;
`ifdef BPSK_MOD_DIFF_ENC_EN
            d_q     <= d_d;
            last_q  <= last_d;
`endif
        end
    end

    // Bit 1 rotates the carrier by half a turn: toggle the MSB of the phase index.
    assign idx = acc_q[ACC_W-1 -: IDX_W] ^ {flip_q, {(IDX_W-1){1'b0}}};

    bpsk_sine_lut #(
        .IDX_W (IDX_W),
        .DAC_W (DAC_W)
    ) u_lut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .idx_i    (idx),
        .sample_o (sample)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate1_q   <= 1'b0;
            strobe1_q <= 1'b0;
            dac_q     <= DAC_W'(DAC_MID);
            strobe2_q <= 1'b0;
        end else if (en) begin
            gate1_q   <= (state_q == RUN);
            strobe1_q <= first_q;
            dac_q     <= gate1_q ? ($unsigned(sample) + DAC_W'(DAC_MID)) : DAC_W'(DAC_MID);
            strobe2_q <= strobe1_q;
        end
    end

    assign bit_ready  = ready_c;
    assign dac_data   = dac_q;
    assign sym_strobe = strobe2_q;
    assign busy       = (state_q == RUN);
    assign underflow  = uf_q;

endmodule

// File: tb/tb_bpsk_mod.sv
// Randomised scoreboard bench for bpsk_mod; reference carrier computed with $sin.
`timescale 1ns/1ps
module tb_bpsk_mod;

`ifdef BPSK_MOD_DIFF_ENC_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] fcw;
    logic [15:0] sym_len;
    logic        bit_valid;
    logic        bit_data;
    logic        in_last;
    logic        bit_ready;
    logic [9:0]  dac_data;
    logic        sym_strobe;
    logic        busy;
    logic        underflow;

    bpsk_mod dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fcw        (fcw),
        .sym_len    (sym_len),
        .bit_valid  (bit_valid),
        .bit_data   (bit_data),
`ifdef BPSK_MOD_DIFF_ENC_EN
        .in_last    (in_last),
`endif
        .bit_ready  (bit_ready),
        .dac_data   (dac_data),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp_v, input int tol);
        int diff;
        n_checks++;
        diff = act - exp_v;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, exp_v, tol, $time);
        end
    endtask

    function automatic int ref_dac(input int idx);
        real r;
        r = 511.0 * $sin(2.0 * 3.14159265358979 * real'(idx) / 1024.0);
        return 512 + $rtoi(r + ((r >= 0.0) ? 0.5 : -0.5));
    endfunction

    // Reference model: symbol timing from the handshake rules, output delayed 2 enabled cycles.
    logic [11:0] exp_q[$];
    logic [11:0] cur;
    bit          started = 1'b0;
    bit          adv     = 1'b0;
    bit [31:0]   m_phase;
    bit          m_run, m_flip, m_d, m_last, m_uf;
    int          m_left, m_len;

    function automatic logic [11:0] mk(input bit run, input bit strobe, input bit [31:0] ph, input bit flip);
        int idx;
        idx = int'(ph >> 22) ^ (flip ? 512 : 0);
        return {run, strobe, idx[9:0]};
    endfunction

    always @(posedge clk) begin
        bit rdy, strobe;
        if (!rst_n) begin
            m_phase = 0; m_run = 0; m_flip = 0; m_d = 0; m_last = 0; m_uf = 0;
            m_left = 0; m_len = 2;
            exp_q.delete();
            exp_q.push_back(12'h0);
            exp_q.push_back(12'h0);
            exp_q.push_back(12'h0);
            adv = 1'b1;
            started = 1'b1;
        end else if (en && started) begin
            m_phase = m_phase + fcw;
            rdy = !m_run || (m_left == 1);
            strobe = 1'b0;
            if (bit_valid && rdy) begin
                if (!m_run) begin
                    m_len = (sym_len < 2) ? 2 : int'(sym_len);
                    m_d = 1'b0;
                    m_run = 1'b1;
                end
                m_flip = DIFF ? (m_d ^ bit_data) : bit_data;
                m_d = m_flip;
                m_last = in_last;
                m_left = m_len;
                strobe = 1'b1;
            end else if (m_run && m_left == 1) begin
                m_run = 1'b0;
                if (!(DIFF && m_last)) m_uf = 1'b1;
            end else if (m_run) begin
                m_left = m_left - 1;
            end
            exp_q.push_back(mk(m_run, strobe, m_phase, m_flip));
            adv = 1'b1;
        end
    end

    // Monitor: consume one expected sample per enabled cycle and compare.
    always @(negedge clk) begin
        int idx;
        if (started) begin
            if (adv) begin
                adv = 1'b0;
                if (exp_q.size() == 0) chk("queue_empty", 0, 1, 0);
                else cur = exp_q.pop_front();
            end
            idx = int'(cur[9:0]);
            if (cur[11]) chk("dac_data", int'(dac_data), ref_dac(idx), (idx % 256 == 0) ? 0 : 1);
            else         chk("dac_idle", int'(dac_data), 512, 0);
            chk("sym_strobe", int'(sym_strobe), int'(cur[10]), 0);
            chk("busy", int'(busy), int'(m_run), 0);
            chk("underflow", int'(underflow), int'(m_uf), 0);
            chk("bit_ready", int'(bit_ready), int'(rst_n && en && (!m_run || m_left == 1)), 0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bit_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        bit_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b, input logic last);
        int n;
        n = 0;
        bit_valid = 1'b1;
        bit_data  = b;
        in_last   = last;
        #1;
        while (!bit_ready && n < 64) begin
            step();
            n++;
        end
        if (!bit_ready) chk("handshake_timeout", 0, 1, 0);
        step();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; fcw = 32'h4000_0000; sym_len = 16'd8;
        bit_valid = 1'b0; bit_data = 1'b0; in_last = 1'b0;
        step();
        do_reset();
        idle(5);

        sym_len = 16'd8;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(12);

        do_reset();
        sym_len = 16'd4;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(8);

        do_reset();
        sym_len = 16'd5;
        send_bit(1'b1, 1'b0);
        idle(10);

        do_reset();
        sym_len = 16'd0;
        send_bit(1'b0, 1'b0);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(6);

        sym_len = 16'd8;
        send_bit(1'b1, 1'b0);
        repeat (3) step();
        do_reset();
        idle(4);

`ifdef BPSK_MOD_DIFF_ENC_EN
        do_reset();
        sym_len = 16'd3;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        idle(8);
`endif

        for (int f = 0; f < 40; f++) begin
            int nb;
            if ($urandom_range(0, 7) == 0) do_reset();
            sym_len = 16'($urandom_range(0, 6));
            fcw = $urandom;
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                send_bit(1'($urandom_range(0, 1)), (i == nb - 1));
                if ($urandom_range(0, 3) == 0) begin
                    en = 1'b0;
                    repeat ($urandom_range(1, 3)) step();
                    en = 1'b1;
                end
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 6));
                if ($urandom_range(0, 7) == 0) fcw = $urandom;
            end
            idle($urandom_range(2, 10));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
